dsc_s2b_frame: RTL and testbench

Framed stochastic-to-binary decoder for the deterministic stochastic computing (DSC) datapath. It is the receiving end of the SNG chain: it takes one serial unary/stochastic bitstream of exactly 2^(SN_WIDTH*NUM_INPUTS) bits per frame and counts the ones. It returns the count as a binary result with a valid/ready output handshake. It sits after the AND-gate product of the clock-divided SNG streams and replaces the free-running output counter, adding frame control and a full-scale-safe result width.

---
 rtl/dsc_s2b_frame_if.sv | 23 ++
 rtl/dsc_s2b_frame.sv | 85 ++++++++
 tb/tb_dsc_s2b_frame.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsc_s2b_frame_if.sv
// Handshake bundle for the framed stochastic-to-binary decoder.
// master = frame source / result consumer, slave = decoder.
interface dsc_s2b_frame_if #(
  parameter int W = 16
);
  logic         start;
  logic         en;
  logic         sn_in;
  logic [W:0]   z;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  modport master (
    output start, en, sn_in, out_ready,
    input  z, out_valid, busy
  );

  modport slave (
    input  start, en, sn_in, out_ready,
    output z, out_valid, busy
  );
endinterface

// File: rtl/dsc_s2b_frame.sv
// Framed stochastic-to-binary decoder: counts the ones in one frame of 2^W
// qualified bitstream samples and presents the count through a valid/ready port.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; z keeps the last completed result
// S_ACCUM | counting qualified samples (en=1) until L have been taken
// S_DONE  | result valid on z, waiting for out_ready
module dsc_s2b_frame #(
  parameter int SN_WIDTH   = 4,
  parameter int NUM_INPUTS = 4
) (
  input logic             clk,
  input logic             rst,
  dsc_s2b_frame_if.slave  bus
);

  localparam int W = SN_WIDTH * NUM_INPUTS;
  localparam logic [W:0] FRAME_LEN = {1'b1, {W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [W:0] cnt_q, cnt_d;
  logic [W:0] acc_q, acc_d;
  logic [W:0] z_q, z_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  // W+1 bit counters hold the full-scale value L, so an all-ones frame never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      S_ACCUM: begin
        if (bus.en) begin
          cnt_d = cnt_q + {{W{1'b0}}, 1'b1};
          acc_d = acc_q + {{W{1'b0}}, bus.sn_in};
          if (cnt_d == FRAME_LEN) begin
            z_d     = acc_d;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.z         = z_q;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dsc_s2b_frame.sv
// Bench for dsc_s2b_frame: a small-frame instance (L=16) and a wide instance
// (L=4096) checked through expected-result queues and per-instance monitors.
module tb_dsc_s2b_frame;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsc_s2b_frame_if #(.W(4))  ia ();
  dsc_s2b_frame_if #(.W(12)) ib ();

  dsc_s2b_frame #(.SN_WIDTH(2), .NUM_INPUTS(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  dsc_s2b_frame #(.SN_WIDTH(3), .NUM_INPUTS(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  typedef struct {
    logic [16:0] z;
    int          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_err = 0;

  int gaps[7] = '{2, 5, 8, 11, 14, 17, 20};
  int ones[5] = '{0, 4, 9, 15, 22};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: result value, ACCUM-to-valid latency, and idle after handshake.
  logic va_q = 1'b0;
  int   run_a = 0;
  bit   idle_chk_a = 1'b0;
  always @(negedge clk) begin
    if (idle_chk_a) begin
      check("a_idle_after_hs", {30'b0, ia.busy, ia.out_valid}, 32'd0);
      idle_chk_a = 1'b0;
    end
    if (ia.out_valid) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_valid: got z=%0h, wanted no result at %0t", ia.z, $time);
      end else begin
        if (!va_q) check("a_latency", run_a, qa[0].lat);
        check("a_z", {27'b0, ia.z}, {15'b0, qa[0].z});
        if (ia.out_ready) begin
          void'(qa.pop_front());
          idle_chk_a = 1'b1;
        end
      end
    end
    if (!ia.busy) run_a = 0;
    else if (!ia.out_valid) run_a++;
    va_q = ia.out_valid;
  end

  logic vb_q = 1'b0;
  int   run_b = 0;
  bit   idle_chk_b = 1'b0;
  always @(negedge clk) begin
    if (idle_chk_b) begin
      check("b_idle_after_hs", {30'b0, ib.busy, ib.out_valid}, 32'd0);
      idle_chk_b = 1'b0;
    end
    if (ib.out_valid) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_valid: got z=%0h, wanted no result at %0t", ib.z, $time);
      end else begin
        if (!vb_q) check("b_latency", run_b, qb[0].lat);
        check("b_z", {19'b0, ib.z}, {15'b0, qb[0].z});
        if (ib.out_ready) begin
          void'(qb.pop_front());
          idle_chk_b = 1'b1;
        end
      end
    end
    if (!ib.busy) run_b = 0;
    else if (!ib.out_valid) run_b++;
    vb_q = ib.out_valid;
  end

  task automatic frame_a(input int n, input logic [63:0] en_pat, input logic [63:0] sn_pat,
                         input logic [16:0] z_exp, input logic rdy);
    ia.out_ready = rdy;
    ia.start = 1'b1;
    qa.push_back('{z: z_exp, lat: n});
    tick();
    ia.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ia.en    = en_pat[i];
      ia.sn_in = sn_pat[i];
      tick();
    end
    ia.en    = 1'b0;
    ia.sn_in = 1'b0;
  endtask

  task automatic frame_b(input logic bitval, input logic [16:0] z_exp);
    ib.out_ready = 1'b1;
    ib.start = 1'b1;
    qb.push_back('{z: z_exp, lat: 4096});
    tick();
    ib.start = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ib.en    = 1'b1;
      ib.sn_in = bitval;
      tick();
    end
    ib.en    = 1'b0;
    ib.sn_in = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit);
    int k = 0;
    while (ia.busy && k < limit) begin
      tick();
      k++;
    end
    if (ia.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL a_timeout: busy still 1 after %0d cycles, wanted 0", limit);
    end
  endtask

  task automatic wait_idle_b(input int limit);
    int k = 0;
    while (ib.busy && k < limit) begin
      tick();
      k++;
    end
    if (ib.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL b_timeout: busy still 1 after %0d cycles, wanted 0", limit);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] en_p;
    logic [63:0] sn_p;

    rst = 1'b1;
    ia.start = 1'b0; ia.en = 1'b0; ia.sn_in = 1'b0; ia.out_ready = 1'b0;
    ib.start = 1'b0; ib.en = 1'b0; ib.sn_in = 1'b0; ib.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset then idle with out_ready toggling.
    for (int i = 0; i < 10; i++) begin
      ia.out_ready = i[0];
      tick();
      check("idle_z", {27'b0, ia.z}, 32'd0);
      check("idle_valid_busy", {30'b0, ia.out_valid, ia.busy}, 32'd0);
    end
    check("b_reset_z", {19'b0, ib.z}, 32'd0);

    // Full-scale frame.
    frame_a(16, '1, '1, 17'd16, 1'b1);
    wait_idle_a(5);

    // Backpressure with a start pulse during the hold.
    frame_a(16, '1, '0, 17'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ia.start = (i == 5);
      tick();
    end
    ia.start = 1'b0;
    check("bp_valid_held", {31'b0, ia.out_valid}, 32'd1);
    ia.out_ready = 1'b1;
    wait_idle_a(5);
    repeat (3) tick();
    check("bp_single_hs", {30'b0, ia.out_valid, ia.busy}, 32'd0);

    // Gapped frame: 5 ones among 16 qualified samples, 7 en=0 cycles with sn_in=1.
    en_p = '0;
    sn_p = '0;
    for (int i = 0; i < 23; i++) en_p[i] = 1'b1;
    foreach (gaps[i]) begin
      en_p[gaps[i]] = 1'b0;
      sn_p[gaps[i]] = 1'b1;
    end
    foreach (ones[i]) sn_p[ones[i]] = 1'b1;
    frame_a(23, en_p, sn_p, 17'd5, 1'b1);
    wait_idle_a(5);
    repeat (2) tick();
    check("z_hold_idle", {27'b0, ia.z}, 32'd5);

    // Reset mid-frame.
    ia.start = 1'b1;
    tick();
    ia.start = 1'b0;
    ia.en = 1'b1;
    ia.sn_in = 1'b1;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.en = 1'b0;
    ia.sn_in = 1'b0;
    check("midrst_z", {27'b0, ia.z}, 32'd0);
    check("midrst_valid_busy", {30'b0, ia.out_valid, ia.busy}, 32'd0);
    tick();
    check("midrst_stays_idle", {31'b0, ia.busy}, 32'd0);

    frame_a(16, '1, 64'h5555, 17'd8, 1'b1);
    wait_idle_a(5);

    // rst dominates start.
    ia.start = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ia.start = 1'b0;
    check("rst_over_start", {31'b0, ia.busy}, 32'd0);
    tick();
    check("rst_over_start_late", {31'b0, ia.busy}, 32'd0);

    // Reset while holding a valid result.
    frame_a(16, '1, '1, 17'd16, 1'b0);
    check("done_valid", {31'b0, ia.out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(qa.pop_front());
    check("donerst_z", {27'b0, ia.z}, 32'd0);
    check("donerst_valid_busy", {30'b0, ia.out_valid, ia.busy}, 32'd0);

    // Wide instance: full-scale without wrap, then an empty frame.
    frame_b(1'b1, 17'h1000);
    wait_idle_b(5);
    check("b_hold_full", {19'b0, ib.z}, 32'h1000);
    frame_b(1'b0, 17'd0);
    wait_idle_b(5);

    repeat (3) tick();
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
